// File: rtl/core_seq_ctrl_pkg.sv
// rtl/core_seq_ctrl_pkg.sv - shared sizes, counter widths and FSM state codes for the core sequencer
package core_seq_ctrl_pkg;

    // Sequence shape
    localparam int ROWS       = 8;
    localparam int NUM_KIJ    = 9;
    localparam int ACT_WORDS  = 36;
    localparam int OUT_WORDS  = 16;
    localparam int SETTLE_CYC = 4;
    localparam int DRAIN_TMO  = 64;

    // SRAM port geometry
    localparam int W_AW   = 7;
    localparam int W_DW   = 32;
    localparam int ACT_AW = 7;
    localparam int ACT_DW = 32;
    localparam int OP_AW  = 4;
    localparam int OP_DW  = 128;

    // Counter widths; cnt is shared by LOAD_W, SETTLE and EXEC so it sizes to the longest phase
    localparam int CNT_W = $clog2(ACT_WORDS);
    localparam int KIJ_W = $clog2(NUM_KIJ);
    localparam int OUT_W = $clog2(OUT_WORDS) + 1;
    localparam int TMO_W = $clog2(DRAIN_TMO) + 1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LOAD_W = 3'd1;
    localparam state_t S_SETTLE = 3'd2;
    localparam state_t S_EXEC   = 3'd3;
    localparam state_t S_DRAIN  = 3'd4;
    localparam state_t S_DONE   = 3'd5;

endpackage

// File: rtl/core_seq_ctrl_if.sv
// rtl/core_seq_ctrl_if.sv - control, host SRAM, muxed SRAM and array/OFIFO signals of the sequencer
interface core_seq_ctrl_if;
    import core_seq_ctrl_pkg::*;

    logic              seq_begin;
    logic              cl_sel;
    logic              seq_done;
    logic              busy;
    logic              abort;

    logic              host_w_cen;
    logic              host_w_wen;
    logic [W_AW-1:0]   host_w_addr;
    logic [W_DW-1:0]   host_w_d;
    logic              host_act_cen;
    logic              host_act_wen;
    logic [ACT_AW-1:0] host_act_addr;
    logic [ACT_DW-1:0] host_act_d;
    logic              host_op_cen;
    logic              host_op_wen;
    logic [OP_AW-1:0]  host_op_addr;
    logic [OP_DW-1:0]  host_op_d;

    logic              w_cen;
    logic              w_wen;
    logic [W_AW-1:0]   w_addr;
    logic [W_DW-1:0]   w_d;
    logic              act_cen;
    logic              act_wen;
    logic [ACT_AW-1:0] act_addr;
    logic [ACT_DW-1:0] act_d;
    logic              op_cen;
    logic              op_wen;
    logic [OP_AW-1:0]  op_addr;
    logic [OP_DW-1:0]  op_d;

    logic              arr_load;
    logic              arr_exec;
    logic              acc_en;
    logic              ofifo_valid;
    logic              ofifo_rd;

    modport slave (
        input  seq_begin, cl_sel, ofifo_valid,
        input  host_w_cen, host_w_wen, host_w_addr, host_w_d,
        input  host_act_cen, host_act_wen, host_act_addr, host_act_d,
        input  host_op_cen, host_op_wen, host_op_addr, host_op_d,
        output seq_done, busy, abort,
        output w_cen, w_wen, w_addr, w_d,
        output act_cen, act_wen, act_addr, act_d,
        output op_cen, op_wen, op_addr, op_d,
        output arr_load, arr_exec, acc_en, ofifo_rd
    );

    modport master (
        output seq_begin, cl_sel, ofifo_valid,
        output host_w_cen, host_w_wen, host_w_addr, host_w_d,
        output host_act_cen, host_act_wen, host_act_addr, host_act_d,
        output host_op_cen, host_op_wen, host_op_addr, host_op_d,
        input  seq_done, busy, abort,
        input  w_cen, w_wen, w_addr, w_d,
        input  act_cen, act_wen, act_addr, act_d,
        input  op_cen, op_wen, op_addr, op_d,
        input  arr_load, arr_exec, acc_en, ofifo_rd
    );

endinterface

// File: rtl/core_seq_ctrl_sram_port_mux.sv
// rtl/core_seq_ctrl_sram_port_mux.sv - 2:1 SRAM port mux between host and sequencer
module sram_port_mux #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          sel_i,
    input  logic          host_cen_i,
    input  logic          host_wen_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_d_i,
    input  logic          ctrl_cen_i,
    input  logic          ctrl_wen_i,
    input  logic [AW-1:0] ctrl_addr_i,
    input  logic [DW-1:0] ctrl_d_i,
    output logic          cen_o,
    output logic          wen_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] d_o
);

    // Host wins whenever sel is high, with no dependence on reset or sequencer state
    always_comb begin
        if (sel_i) begin
            cen_o  = host_cen_i;
            wen_o  = host_wen_i;
            addr_o = host_addr_i;
            d_o    = host_d_i;
        end else begin
            cen_o  = ctrl_cen_i;
            wen_o  = ctrl_wen_i;
            addr_o = ctrl_addr_i;
            d_o    = ctrl_d_i;
        end
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - kernel-pass sequencer and SRAM port owner for the systolic core
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    core_seq_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] ROWS_LAST   = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ACT_LAST    = CNT_W'(ACT_WORDS - 1);
    localparam logic [KIJ_W-1:0] KIJ_LAST    = KIJ_W'(NUM_KIJ - 1);
    localparam logic [OUT_W-1:0] OUT_LAST    = OUT_W'(OUT_WORDS - 1);
    localparam logic [OUT_W-1:0] OUT_MAX     = OUT_W'(OUT_WORDS);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(DRAIN_TMO - 1);

    state_t             state_q, state_d;
    logic [KIJ_W-1:0]   kij_q, kij_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [TMO_W-1:0]   idle_q, idle_d;
    logic               abort_q, abort_d;
    logic               arr_load_q;
    logic               arr_exec_q;

    logic               w_rd;
    logic               act_rd;
    logic               pop;
    logic               takeover;
    logic [W_AW-1:0]    w_addr_c;
    logic [ACT_AW-1:0]  act_addr_c;
    logic [OP_AW-1:0]   op_addr_c;

    // Strobes are suppressed while the host owns the ports so no phantom reads or pops reach the array/OFIFO
    assign w_rd     = (state_q == S_LOAD_W) && !bus.cl_sel;
    assign act_rd   = (state_q == S_EXEC) && !bus.cl_sel;
    assign pop      = (state_q == S_DRAIN) && !bus.cl_sel && bus.ofifo_valid && (out_cnt_q < OUT_MAX);
    assign takeover = bus.cl_sel && (state_q != S_IDLE) && (state_q != S_DONE);

    assign w_addr_c   = w_rd ? (W_AW'(kij_q * ROWS) + W_AW'(cnt_q)) : '0;
    assign act_addr_c = act_rd ? ACT_AW'(cnt_q) : '0;
    assign op_addr_c  = pop ? OP_AW'(out_cnt_q) : '0;

    // Next-state and counter update; host takeover overrides every phase
    always_comb begin
        state_d   = state_q;
        kij_d     = kij_q;
        cnt_d     = cnt_q;
        out_cnt_d = out_cnt_q;
        idle_d    = idle_q;
        abort_d   = 1'b0;
        if (takeover) begin
            state_d   = S_IDLE;
            kij_d     = '0;
            cnt_d     = '0;
            out_cnt_d = '0;
            idle_d    = '0;
            abort_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.seq_begin && !bus.cl_sel) begin
                        state_d = S_LOAD_W;
                        kij_d   = '0;
                        cnt_d   = '0;
                    end
                end
                S_LOAD_W: begin
                    if (cnt_q == ROWS_LAST) begin
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == ACT_LAST) begin
                        cnt_d     = '0;
                        out_cnt_d = '0;
                        idle_d    = '0;
                        state_d   = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (pop) begin
                        idle_d = '0;
                        // Leave on the last pop itself so a stall-free drain costs exactly OUT_WORDS cycles
                        if (out_cnt_q == OUT_LAST) begin
                            out_cnt_d = '0;
                            if (kij_q == KIJ_LAST) begin
                                kij_d   = '0;
                                state_d = S_DONE;
                            end else begin
                                kij_d   = kij_q + 1'b1;
                                state_d = S_LOAD_W;
                            end
                        end else begin
                            out_cnt_d = out_cnt_q + 1'b1;
                        end
                    end else if (idle_q == TMO_LAST) begin
                        state_d   = S_IDLE;
                        kij_d     = '0;
                        out_cnt_d = '0;
                        idle_d    = '0;
                        abort_d   = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counters, abort pulse and the one-cycle SRAM read-latency delay for array strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            kij_q      <= '0;
            cnt_q      <= '0;
            out_cnt_q  <= '0;
            idle_q     <= '0;
            abort_q    <= 1'b0;
            arr_load_q <= 1'b0;
            arr_exec_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            kij_q      <= kij_d;
            cnt_q      <= cnt_d;
            out_cnt_q  <= out_cnt_d;
            idle_q     <= idle_d;
            abort_q    <= abort_d;
            arr_load_q <= w_rd;
            arr_exec_q <= act_rd;
        end
    end

    assign bus.seq_done = (state_q == S_DONE);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.abort    = abort_q;
    assign bus.arr_load = arr_load_q;
    assign bus.arr_exec = arr_exec_q;
    assign bus.ofifo_rd = pop;
    assign bus.acc_en   = pop && (kij_q != '0);

    sram_port_mux #(.AW(W_AW), .DW(W_DW)) u_w_mux (
        .sel_i       (bus.cl_sel),
        .host_cen_i  (bus.host_w_cen),
        .host_wen_i  (bus.host_w_wen),
        .host_addr_i (bus.host_w_addr),
        .host_d_i    (bus.host_w_d),
        .ctrl_cen_i  (!w_rd),
        .ctrl_wen_i  (1'b1),
        .ctrl_addr_i (w_addr_c),
        .ctrl_d_i    ('0),
        .cen_o       (bus.w_cen),
        .wen_o       (bus.w_wen),
        .addr_o      (bus.w_addr),
        .d_o         (bus.w_d)
    );

    sram_port_mux #(.AW(ACT_AW), .DW(ACT_DW)) u_act_mux (
        .sel_i       (bus.cl_sel),
        .host_cen_i  (bus.host_act_cen),
        .host_wen_i  (bus.host_act_wen),
        .host_addr_i (bus.host_act_addr),
        .host_d_i    (bus.host_act_d),
        .ctrl_cen_i  (!act_rd),
        .ctrl_wen_i  (1'b1),
        .ctrl_addr_i (act_addr_c),
        .ctrl_d_i    ('0),
        .cen_o       (bus.act_cen),
        .wen_o       (bus.act_wen),
        .addr_o      (bus.act_addr),
        .d_o         (bus.act_d)
    );

    // Controller-side psum data is zero: the SFU supplies the real write data
    sram_port_mux #(.AW(OP_AW), .DW(OP_DW)) u_op_mux (
        .sel_i       (bus.cl_sel),
        .host_cen_i  (bus.host_op_cen),
        .host_wen_i  (bus.host_op_wen),
        .host_addr_i (bus.host_op_addr),
        .host_d_i    (bus.host_op_d),
        .ctrl_cen_i  (!pop),
        .ctrl_wen_i  (!pop),
        .ctrl_addr_i (op_addr_c),
        .ctrl_d_i    ('0),
        .cen_o       (bus.op_cen),
        .wen_o       (bus.op_wen),
        .addr_o      (bus.op_addr),
        .d_o         (bus.op_d)
    );

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - randomized self-checking bench for core_seq_ctrl against a pass-timeline model
module tb_core_seq_ctrl;
    import core_seq_ctrl_pkg::*;

    localparam int PASS_CYC = ROWS + SETTLE_CYC + ACT_WORDS + OUT_WORDS;
    localparam int EXEC_OFF = ROWS + SETTLE_CYC;
    localparam int DRN_OFF  = ROWS + SETTLE_CYC + ACT_WORDS;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    core_seq_ctrl_if bus();

    core_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the sequence timeline
    int cyc;
    bit m_active;
    int m_pass, m_start, m_pops, m_idle;
    int m_done_cyc, m_abort_cyc;
    bit m_prev_w, m_prev_a;
    int host_seq = -1;

    // Observed events within one scenario
    int n_done, n_abort, obs_done_cyc, obs_abort_cyc;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit vld_pick(input int mode);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ($urandom_range(0, 4) != 0);
            default: return cyc[0];
        endcase
    endfunction

    // One clock: drive inputs, compare every output to the model, advance model
    task automatic tick(input bit rst, input bit sb, input bit cs, input bit vld);
        logic [255:0] obs, exp;
        logic [40:0]  e_w, e_a;
        logic [133:0] e_o;
        int  off;
        bit  wrd, ard, drn, rd, e_done, e_abort, e_busy, e_acc;

        reset           = rst;
        bus.seq_begin   = sb;
        bus.cl_sel      = cs;
        bus.ofifo_valid = vld;
        if (host_seq >= 0) begin
            bus.host_w_cen  = 1'b0;
            bus.host_w_wen  = (host_seq >= NUM_KIJ * ROWS);
            bus.host_w_addr = W_AW'(host_seq % (NUM_KIJ * ROWS));
            host_seq++;
        end else begin
            bus.host_w_cen  = 1'($urandom);
            bus.host_w_wen  = 1'($urandom);
            bus.host_w_addr = W_AW'($urandom);
        end
        bus.host_w_d      = $urandom;
        bus.host_act_cen  = 1'($urandom);
        bus.host_act_wen  = 1'($urandom);
        bus.host_act_addr = ACT_AW'($urandom);
        bus.host_act_d    = $urandom;
        bus.host_op_cen   = 1'($urandom);
        bus.host_op_wen   = 1'($urandom);
        bus.host_op_addr  = OP_AW'($urandom);
        bus.host_op_d     = {$urandom, $urandom, $urandom, $urandom};
        #1;

        off     = cyc - m_start;
        wrd     = m_active && !cs && off < ROWS;
        ard     = m_active && !cs && off >= EXEC_OFF && off < DRN_OFF;
        drn     = m_active && off >= DRN_OFF;
        rd      = drn && vld && !cs;
        e_done  = (cyc == m_done_cyc);
        e_abort = (cyc == m_abort_cyc);
        e_busy  = m_active || e_done;
        e_acc   = rd && (m_pass != 0);

        if (cs) begin
            e_w = {bus.host_w_cen, bus.host_w_wen, bus.host_w_addr, bus.host_w_d};
            e_a = {bus.host_act_cen, bus.host_act_wen, bus.host_act_addr, bus.host_act_d};
            e_o = {bus.host_op_cen, bus.host_op_wen, bus.host_op_addr, bus.host_op_d};
        end else begin
            e_w = {!wrd, 1'b1, (wrd ? W_AW'(m_pass * ROWS + off) : W_AW'(0)), 32'd0};
            e_a = {!ard, 1'b1, (ard ? ACT_AW'(off - EXEC_OFF) : ACT_AW'(0)), 32'd0};
            e_o = {!rd, !rd, (rd ? OP_AW'(m_pops) : OP_AW'(0)), 128'd0};
        end

        obs = 256'({bus.busy, bus.seq_done, bus.abort, bus.arr_load, bus.arr_exec, bus.acc_en, bus.ofifo_rd,
                    bus.w_cen, bus.w_wen, bus.w_addr, bus.w_d,
                    bus.act_cen, bus.act_wen, bus.act_addr, bus.act_d,
                    bus.op_cen, bus.op_wen, bus.op_addr, bus.op_d});
        exp = 256'({e_busy, e_done, e_abort, m_prev_w, m_prev_a, e_acc, rd, e_w, e_a, e_o});
        check($sformatf("cyc%0d", cyc), obs, exp);

        if (bus.seq_done === 1'b1) begin n_done++; obs_done_cyc = cyc; end
        if (bus.abort === 1'b1) begin n_abort++; obs_abort_cyc = cyc; end

        if (rst) begin
            m_active    = 1'b0;
            m_prev_w    = 1'b0;
            m_prev_a    = 1'b0;
            m_done_cyc  = -1;
            m_abort_cyc = -1;
        end else begin
            m_prev_w = wrd;
            m_prev_a = ard;
            if (m_active && cs) begin
                m_active    = 1'b0;
                m_abort_cyc = cyc + 1;
            end else if (m_active) begin
                if (rd) begin
                    m_pops++;
                    m_idle = 0;
                    if (m_pops == OUT_WORDS) begin
                        m_pops  = 0;
                        m_pass++;
                        m_start = cyc + 1;
                        if (m_pass == NUM_KIJ) begin
                            m_active   = 1'b0;
                            m_done_cyc = cyc + 1;
                        end
                    end
                end else if (drn) begin
                    m_idle++;
                    if (m_idle == DRAIN_TMO) begin
                        m_active    = 1'b0;
                        m_abort_cyc = cyc + 1;
                    end
                end
            end else if (cyc != m_done_cyc && sb && !cs) begin
                m_active = 1'b1;
                m_pass   = 0;
                m_start  = cyc + 1;
                m_pops   = 0;
                m_idle   = 0;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_obs();
        n_done        = 0;
        n_abort       = 0;
        obs_done_cyc  = -1;
        obs_abort_cyc = -1;
    endtask

    // Start a sequence and run it out; optional host takeover at EXEC offset 20 of a chosen pass
    task automatic run_seq(input int vmode, input int tko_pass, input int budget, output int start);
        int n;
        bit cs;
        clear_obs();
        start = cyc;
        tick(1'b0, 1'b1, 1'b0, vld_pick(vmode));
        n = 0;
        while ((m_active || cyc <= m_done_cyc || cyc <= m_abort_cyc) && n < budget) begin
            cs = m_active && (tko_pass >= 0) && (m_pass == tko_pass) && (cyc - m_start == EXEC_OFF + 8);
            tick(1'b0, m_active && ($urandom_range(0, 7) == 0), cs, vld_pick(vmode));
            n++;
        end
        check("run_bound", 256'(n < budget), 256'(1));
    endtask

    initial begin
        int st;

        reset             = 1'b1;
        bus.seq_begin     = 1'b0;
        bus.cl_sel        = 1'b0;
        bus.ofifo_valid   = 1'b0;
        bus.host_w_cen    = 1'b1;
        bus.host_w_wen    = 1'b1;
        bus.host_w_addr   = '0;
        bus.host_w_d      = '0;
        bus.host_act_cen  = 1'b1;
        bus.host_act_wen  = 1'b1;
        bus.host_act_addr = '0;
        bus.host_act_d    = '0;
        bus.host_op_cen   = 1'b1;
        bus.host_op_wen   = 1'b1;
        bus.host_op_addr  = '0;
        bus.host_op_d     = '0;
        cyc         = 0;
        m_active    = 1'b0;
        m_pass      = 0;
        m_start     = 0;
        m_pops      = 0;
        m_idle      = 0;
        m_done_cyc  = -1;
        m_abort_cyc = -1;
        m_prev_w    = 1'b0;
        m_prev_a    = 1'b0;
        clear_obs();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values with controller owning the ports
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_busy", 256'(bus.busy), 256'(0));

        // Host ownership: write then read W 0..71, mux transparent even under reset
        host_seq = 0;
        for (int i = 0; i < 2 * NUM_KIJ * ROWS; i++)
            tick(i < 5, $urandom_range(0, 3) == 0, 1'b1, 1'($urandom));
        host_seq = -1;
        check("host_busy", 256'(bus.busy), 256'(0));

        // Stall-free full sequence
        run_seq(1, -1, 800, st);
        check("done_lat", 256'(obs_done_cyc - st), 256'(PASS_CYC * NUM_KIJ + 1));
        check("done_cnt", 256'(n_done), 256'(1));
        check("abort_cnt_a", 256'(n_abort), 256'(0));

        // Toggling and random OFIFO availability
        run_seq(3, -1, 2000, st);
        check("done_cnt_tog", 256'(n_done), 256'(1));
        run_seq(2, -1, 2000, st);
        check("done_cnt_rnd", 256'(n_done), 256'(1));
        check("abort_cnt_rnd", 256'(n_abort), 256'(0));

        // Host takeover during EXEC of kij=2
        run_seq(1, 2, 800, st);
        check("tko_lat", 256'(obs_abort_cyc - st), 256'(1 + 2 * PASS_CYC + EXEC_OFF + 8 + 1));
        check("tko_abort_cnt", 256'(n_abort), 256'(1));
        check("tko_done_cnt", 256'(n_done), 256'(0));

        // Drain timeout with OFIFO empty
        run_seq(0, -1, 800, st);
        check("tmo_lat", 256'(obs_abort_cyc - st), 256'(1 + DRN_OFF + DRAIN_TMO));
        check("tmo_done_cnt", 256'(n_done), 256'(0));

        // Reset mid-sequence: silent return to IDLE
        clear_obs();
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (30) tick(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_mid_done", 256'(n_done), 256'(0));
        check("rst_mid_abort", 256'(n_abort), 256'(0));
        check("rst_mid_busy", 256'(bus.busy), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
